// File: rtl/ar_condicionado_multizona.sv
// Multi-zone air-conditioner controller: shared auto-repeat buttons set each zone's desired
// temperature, real temperatures slew toward their targets, and zones held at max drip.
module ar_condicionado_multizona #(
    parameter int NZONES        = 2,
    parameter int NBITS_TEMP    = 4,
    parameter int TEMP_MIN      = 0,
    parameter int TEMP_MAX      = 15,
    parameter int TEMP_AMB      = 8,
    parameter int STEP_DIV      = 2,
    parameter int HOLD_DELAY    = 3,
    parameter int REPEAT_PERIOD = 2,
    parameter int DRIP_START    = 10,
    parameter int DRIP_LEN      = 4,
    localparam int ZW           = (NZONES > 1) ? $clog2(NZONES) : 1
) (
    input  logic                         clk_2,
    input  logic                         reset_n,
    input  logic [ZW-1:0]                zone_sel,
    input  logic                         aumentar,
    input  logic                         diminuir,
    input  logic [NZONES-1:0]            zone_on,
    output logic [NZONES*NBITS_TEMP-1:0] temp_real,
    output logic [NZONES*NBITS_TEMP-1:0] temp_desejada,
    output logic [NZONES-1:0]            pingando,
    output logic [NZONES-1:0]            estavel
);
    localparam int HW = 8;
    localparam int SW = $clog2(STEP_DIV + 1);
    localparam int DW = $clog2(DRIP_START + 1);
    localparam int LW = $clog2(DRIP_LEN + 1);
    localparam logic [NBITS_TEMP-1:0] T_MIN   = NBITS_TEMP'(TEMP_MIN);
    localparam logic [NBITS_TEMP-1:0] T_MAX   = NBITS_TEMP'(TEMP_MAX);
    localparam logic [NBITS_TEMP-1:0] T_AMB   = NBITS_TEMP'(TEMP_AMB);
    localparam logic [NBITS_TEMP:0]   T_MAX_W = (NBITS_TEMP + 1)'(TEMP_MAX);

    typedef enum logic [1:0] {ESTAVEL, AUMENTA, DIMINUI} btn_state_t;

    btn_state_t    state, state_next;
    logic [ZW-1:0] lat_zone, lat_next;
    logic [HW-1:0] hold_cnt, hold_next, hold_inc;
    logic [31:0]   since_delay;
    logic          up, dn, repeat_fire, step_en, step_up;

    assign up          = aumentar & ~diminuir;
    assign dn          = diminuir & ~aumentar;
    assign hold_inc    = (hold_cnt == '1) ? hold_cnt : hold_cnt + HW'(1);
    assign since_delay = 32'(hold_cnt) - 32'(HOLD_DELAY);
    assign repeat_fire = (32'(hold_cnt) >= 32'(HOLD_DELAY)) &&
                         ((since_delay % 32'(REPEAT_PERIOD)) == 32'd0);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ESTAVEL;
            lat_zone <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            lat_zone <= lat_next;
            hold_cnt <= hold_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        lat_next   = lat_zone;
        hold_next  = hold_cnt;
        step_en    = 1'b0;
        step_up    = 1'b0;
        unique case (state)
            ESTAVEL: begin
                if (up || dn) begin
                    step_en    = 1'b1;
                    step_up    = up;
                    lat_next   = zone_sel;
                    hold_next  = '0;
                    state_next = up ? AUMENTA : DIMINUI;
                end
            end
            AUMENTA, DIMINUI: begin
                if ((state == AUMENTA && dn) || (state == DIMINUI && up)) begin
                    // Reversal restarts the press cycle on the currently selected zone.
                    step_en    = 1'b1;
                    step_up    = up;
                    lat_next   = zone_sel;
                    hold_next  = '0;
                    state_next = up ? AUMENTA : DIMINUI;
                end else if ((up || dn) && zone_sel == lat_zone) begin
                    hold_next = hold_inc;
                    step_en   = repeat_fire;
                    step_up   = up;
                end else begin
                    state_next = ESTAVEL;
                end
            end
            default: state_next = ESTAVEL;
        endcase
    end

    logic [NBITS_TEMP-1:0] real_q   [NZONES];
    logic [NBITS_TEMP-1:0] des_q    [NZONES];
    logic [NBITS_TEMP-1:0] real_nx  [NZONES];
    logic [NBITS_TEMP-1:0] des_nx   [NZONES];
    logic [NBITS_TEMP-1:0] target   [NZONES];
    logic [NBITS_TEMP:0]   des_inc  [NZONES];
    logic [DW-1:0]         drip_cnt [NZONES];
    logic [LW-1:0]         len_cnt  [NZONES];
    logic [NZONES-1:0]     ping_q;
    logic [SW-1:0]         step_cnt;
    logic                  tick;

    assign tick = (step_cnt == SW'(STEP_DIV - 1));

    always_comb begin
        for (int z = 0; z < NZONES; z++) begin
            des_inc[z] = {1'b0, des_q[z]} + (NBITS_TEMP + 1)'(1);
            des_nx[z]  = des_q[z];
            target[z]  = zone_on[z] ? des_q[z] : T_AMB;
            real_nx[z] = real_q[z];
            if (step_en && int'(zone_sel) == z) begin
                if (step_up)
                    des_nx[z] = (des_inc[z] > T_MAX_W) ? T_MAX : des_inc[z][NBITS_TEMP-1:0];
                else
                    des_nx[z] = (des_q[z] <= T_MIN) ? T_MIN : des_q[z] - NBITS_TEMP'(1);
            end
            if (tick) begin
                if (real_q[z] < target[z])
                    real_nx[z] = real_q[z] + NBITS_TEMP'(1);
                else if (real_q[z] > target[z])
                    real_nx[z] = real_q[z] - NBITS_TEMP'(1);
            end
        end
    end

    // NOTE: the per-zone arrays are small register banks, not RAM, so all of them are reset.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt <= '0;
            ping_q   <= '0;
            for (int z = 0; z < NZONES; z++) begin
                real_q[z]   <= T_MIN;
                des_q[z]    <= T_MIN;
                drip_cnt[z] <= '0;
                len_cnt[z]  <= '0;
            end
        end else begin
            step_cnt <= tick ? '0 : step_cnt + SW'(1);
            for (int z = 0; z < NZONES; z++) begin
                real_q[z] <= real_nx[z];
                des_q[z]  <= des_nx[z];
                // A started drip always runs its full length regardless of temp or power.
                if (ping_q[z]) begin
                    drip_cnt[z] <= '0;
                    if (len_cnt[z] == LW'(DRIP_LEN - 1)) begin
                        ping_q[z]  <= 1'b0;
                        len_cnt[z] <= '0;
                    end else begin
                        len_cnt[z] <= len_cnt[z] + LW'(1);
                    end
                end else if (zone_on[z] && real_q[z] == T_MAX) begin
                    if (drip_cnt[z] == DW'(DRIP_START - 1)) begin
                        ping_q[z]   <= 1'b1;
                        len_cnt[z]  <= '0;
                        drip_cnt[z] <= '0;
                    end else begin
                        drip_cnt[z] <= drip_cnt[z] + DW'(1);
                    end
                end else begin
                    drip_cnt[z] <= '0;
                end
            end
        end
    end

    assign pingando = ping_q;

    always_comb begin
        temp_real     = '0;
        temp_desejada = '0;
        estavel       = '0;
        for (int z = 0; z < NZONES; z++) begin
            temp_real[z*NBITS_TEMP +: NBITS_TEMP]     = real_q[z];
            temp_desejada[z*NBITS_TEMP +: NBITS_TEMP] = des_q[z];
            estavel[z] = zone_on[z] && (real_q[z] == des_q[z]);
        end
    end
endmodule

// File: tb/tb_ar_condicionado_multizona.sv
// Self-checking bench: a cycle-level behavioural model of the controller, compared every cycle,
// plus hand-computed expectations from directed scenarios and a randomized stimulus phase.
module tb_ar_condicionado_multizona;
    localparam int NZ = 2, NB = 4, TMIN = 0, TMAX = 15, TAMB = 8, SDIV = 2;
    localparam int HD = 3, RP = 2, DS = 10, DL = 4;

    logic              clk_2    = 1'b0;
    logic              reset_n  = 1'b0;
    logic [0:0]        zone_sel = '0;
    logic              aumentar = 1'b0;
    logic              diminuir = 1'b0;
    logic [NZ-1:0]     zone_on  = '0;
    logic [NZ*NB-1:0]  temp_real, temp_desejada;
    logic [NZ-1:0]     pingando, estavel;

    ar_condicionado_multizona #(
        .NZONES(NZ), .NBITS_TEMP(NB), .TEMP_MIN(TMIN), .TEMP_MAX(TMAX), .TEMP_AMB(TAMB),
        .STEP_DIV(SDIV), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .DRIP_START(DS), .DRIP_LEN(DL)
    ) dut (
        .clk_2(clk_2), .reset_n(reset_n), .zone_sel(zone_sel), .aumentar(aumentar),
        .diminuir(diminuir), .zone_on(zone_on), .temp_real(temp_real),
        .temp_desejada(temp_desejada), .pingando(pingando), .estavel(estavel)
    );

    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: temperatures, drip run/remaining counters, and a press session
    // described by direction, zone and age (cycles since the press).
    int m_real [NZ] = '{default: 0};
    int m_des  [NZ] = '{default: 0};
    int m_run  [NZ] = '{default: 0};
    int m_left [NZ] = '{default: 0};
    int m_edges = 0;
    bit m_active = 1'b0;
    int m_dir = 0, m_zone = 0, m_age = 0;

    function automatic void model_reset();
        for (int z = 0; z < NZ; z++) begin
            m_real[z] = TMIN; m_des[z] = TMIN; m_run[z] = 0; m_left[z] = 0;
        end
        m_edges = 0; m_active = 1'b0; m_dir = 0; m_zone = 0; m_age = 0;
    endfunction

    function automatic void model_bump(input int z, input int dir);
        int v;
        v = m_des[z] + ((dir == 1) ? 1 : -1);
        m_des[z] = (v < TMIN) ? TMIN : ((v > TMAX) ? TMAX : v);
    endfunction

    function automatic void model_step();
        int req, sel, tgt;
        req = (aumentar && !diminuir) ? 1 : ((diminuir && !aumentar) ? 2 : 0);
        sel = int'(zone_sel);
        for (int z = 0; z < NZ; z++) begin
            if (m_left[z] > 0) begin
                m_left[z]--; m_run[z] = 0;
            end else if (zone_on[z] && m_real[z] == TMAX) begin
                m_run[z]++;
                if (m_run[z] == DS) begin m_left[z] = DL; m_run[z] = 0; end
            end else begin
                m_run[z] = 0;
            end
        end
        if (m_edges % SDIV == SDIV - 1)
            for (int z = 0; z < NZ; z++) begin
                tgt = zone_on[z] ? m_des[z] : TAMB;
                if (m_real[z] < tgt) m_real[z]++;
                else if (m_real[z] > tgt) m_real[z]--;
            end
        m_edges++;
        if (!m_active) begin
            if (req != 0) begin
                model_bump(sel, req); m_active = 1'b1; m_dir = req; m_zone = sel; m_age = 0;
            end
        end else if (req != 0 && req != m_dir) begin
            model_bump(sel, req); m_dir = req; m_zone = sel; m_age = 0;
        end else if (req == m_dir && sel == m_zone) begin
            m_age++;
            if (m_age >= HD + 1 && (m_age - HD - 1) % RP == 0) model_bump(m_zone, m_dir);
        end else begin
            m_active = 1'b0;
        end
    endfunction

    always @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk_2) begin
        if (chk_en)
            for (int z = 0; z < NZ; z++) begin
                check($sformatf("temp_real[%0d]", z), int'(temp_real[z*NB +: NB]), m_real[z]);
                check($sformatf("temp_desejada[%0d]", z), int'(temp_desejada[z*NB +: NB]), m_des[z]);
                check($sformatf("pingando[%0d]", z), int'(pingando[z]), (m_left[z] > 0) ? 1 : 0);
                check($sformatf("estavel[%0d]", z), int'(estavel[z]),
                      (zone_on[z] && m_real[z] == m_des[z]) ? 1 : 0);
            end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk_2); #2; end
    endtask

    task automatic set_btn(input bit a, input bit d, input int sel);
        aumentar = a; diminuir = d; zone_sel = 1'(sel);
    endtask

    function automatic int des_of(input int z);
        return int'(temp_desejada[z*NB +: NB]);
    endfunction

    function automatic int real_of(input int z);
        return int'(temp_real[z*NB +: NB]);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, len;
        cyc(3);
        chk_en = 1'b1;
        check("reset temp_real", int'(temp_real), 0);
        check("reset temp_desejada", int'(temp_desejada), 0);
        check("reset pingando", int'(pingando), 0);
        reset_n = 1'b1;
        cyc(1);

        set_btn(1, 0, 0); cyc(1); set_btn(0, 0, 0);
        check("single press zone0", des_of(0), 1);
        check("single press zone1 untouched", des_of(1), 0);
        cyc(2);
        set_btn(0, 1, 0); cyc(1); set_btn(0, 0, 0); cyc(2);
        check("single down to 0", des_of(0), 0);

        set_btn(1, 0, 0); cyc(9); set_btn(0, 0, 0);
        check("hold 9 cycles", des_of(0), 4);
        cyc(2);

        set_btn(0, 1, 0); cyc(20);
        check("floor saturation", des_of(0), TMIN);
        set_btn(1, 0, 0); cyc(40);
        check("ceiling saturation", des_of(0), TMAX);
        cyc(6);
        check("ceiling no wrap", des_of(0), TMAX);
        set_btn(0, 0, 0); cyc(2);

        set_btn(1, 1, 0); cyc(5);
        check("both buttons no change", des_of(0), TMAX);
        set_btn(0, 1, 0); cyc(1); set_btn(0, 0, 0);
        check("fresh press after both", des_of(0), TMAX - 1);
        cyc(2);

        set_btn(1, 0, 1); cyc(5);
        check("zone1 hold 5", des_of(1), 2);
        set_btn(1, 0, 0); cyc(1);
        check("zone switch no step", des_of(1), 2);
        set_btn(0, 0, 0); cyc(8);
        check("zone1 repeats stopped", des_of(1), 2);

        reset_n = 1'b0; cyc(2); reset_n = 1'b1;
        zone_on = 2'b01;
        repeat (5) begin set_btn(1, 0, 0); cyc(1); set_btn(0, 0, 0); cyc(1); end
        check("desired 5", des_of(0), 5);
        cyc(30);
        check("real tracks desired", real_of(0), 5);
        check("estavel when settled", int'(estavel[0]), 1);
        zone_on = 2'b00; cyc(30);
        check("off drifts to ambient", real_of(0), TAMB);
        check("estavel off", int'(estavel[0]), 0);

        zone_on = 2'b01;
        set_btn(1, 0, 0); cyc(40); set_btn(0, 0, 0);
        n = 0;
        while (!pingando[0] && n < 300) begin cyc(1); n++; end
        check("drip started within budget", int'(pingando[0]), 1);
        len = 0;
        while (pingando[0] && len < 50) begin len++; cyc(1); end
        check("drip length", len, DL);
        m = 0;
        while (!pingando[0] && m < 50) begin m++; cyc(1); end
        check("drip restart gap", m, DS);
        cyc(1);
        reset_n = 1'b0; #1;
        check("async reset clears pingando", int'(pingando), 0);
        check("async reset clears temp_real", int'(temp_real), 0);
        cyc(2); reset_n = 1'b1;

        for (int seg = 0; seg < 220; seg++) begin
            int r, hold;
            r = $urandom_range(0, 9);
            if (r < 4) set_btn(1, 0, $urandom_range(0, 1));
            else if (r < 7) set_btn(0, 1, $urandom_range(0, 1));
            else if (r == 7) set_btn(1, 1, $urandom_range(0, 1));
            else set_btn(0, 0, $urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) zone_on = NZ'($urandom);
            hold = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
            cyc(hold);
            if ($urandom_range(0, 60) == 0) begin
                reset_n = 1'b0; cyc(1); reset_n = 1'b1;
            end
        end
        set_btn(0, 0, 0);
        cyc(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
